// File: rtl/clk_freq_meter.sv
// Measures period and high time of a slow square wave in clk cycles.
// Define FREQ_METER_AVG4_EN to report the average over 4 consecutive periods.
module clk_freq_meter #(
    parameter int unsigned CNT_W       = 33,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out
);

    localparam int unsigned    SUM_W    = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   hi_done_q, hi_done_d;
    logic [CNT_W-1:0]       hi_cap_q, hi_cap_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
`ifdef FREQ_METER_AVG4_EN
    logic [1:0]             per_q, per_d;
    logic [SUM_W-1:0]       psum_q, psum_d;
    logic [SUM_W-1:0]       hsum_q, hsum_d;
    logic [SUM_W-1:0]       psum_next, hsum_next;
`endif

    logic             s;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt_inc;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~prev_q;
    assign fall    = ~s & prev_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d    = s;
        cnt_d     = cnt_q;
        hi_done_d = hi_done_q;
        hi_cap_d  = hi_cap_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        period_d  = period_q;
        high_d    = high_q;
`ifdef FREQ_METER_AVG4_EN
        per_d     = per_q;
        psum_d    = psum_q;
        hsum_d    = hsum_q;
        psum_next = psum_q + SUM_W'(cnt_inc);
        hsum_next = hsum_q + SUM_W'(hi_cap_q);
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    state_d   = MEASURE;
                    cnt_d     = '0;
                    hi_done_d = 1'b0;
`ifdef FREQ_METER_AVG4_EN
                    per_d     = 2'd0;
                    psum_d    = '0;
                    hsum_d    = '0;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            MEASURE: begin
                // Only the first fall after a rise marks the high time
                if (fall && !hi_done_q) begin
                    hi_cap_d  = cnt_inc;
                    hi_done_d = 1'b1;
                end
                if (rise) begin
`ifdef FREQ_METER_AVG4_EN
                    if (per_q == 2'd3) begin
                        state_d  = IDLE;
                        valid_d  = 1'b1;
                        period_d = CNT_W'(psum_next >> 2);
                        high_d   = CNT_W'(hsum_next >> 2);
                    end else begin
                        per_d     = per_q + 2'd1;
                        psum_d    = psum_next;
                        hsum_d    = hsum_next;
                        cnt_d     = '0;
                        hi_done_d = 1'b0;
                    end
`else
                    state_d  = IDLE;
                    valid_d  = 1'b1;
                    period_d = cnt_inc;
                    high_d   = hi_cap_q;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            hi_done_q <= 1'b0;
            hi_cap_q  <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
`ifdef FREQ_METER_AVG4_EN
            per_q     <= 2'd0;
            psum_q    <= '0;
            hsum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            hi_done_q <= hi_done_d;
            hi_cap_q  <= hi_cap_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            period_q  <= period_d;
            high_q    <= high_d;
`ifdef FREQ_METER_AVG4_EN
            per_q     <= per_d;
            psum_q    <= psum_d;
            hsum_q    <= hsum_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;
    assign period_out = period_q;
    assign high_out   = high_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Randomized bench for clk_freq_meter; expected results come from the generated
// waveform's period/high lengths (averaged over 4 periods with FREQ_METER_AVG4_EN).
module tb_clk_freq_meter;

    localparam int unsigned CW   = 33;
    localparam int unsigned TOUT = 1000;
`ifdef FREQ_METER_AVG4_EN
    localparam int NPER = 4;
`else
    localparam int NPER = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sig_in = 1'b0;
    logic          start = 1'b0;
    logic          busy, valid, timeout;
    logic [CW-1:0] period_out, high_out;

    clk_freq_meter #(.CNT_W(CW), .SYNC_STAGES(2), .TIMEOUT(TOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .start      (start),
        .busy       (busy),
        .valid      (valid),
        .timeout    (timeout),
        .period_out (period_out),
        .high_out   (high_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int to_cnt = 0;
    int busy_cnt = 0;
    int to_cyc = 0;
    logic to_busy = 1'b0;

    // Reference state: last reported result and the waveform to generate
    longint exp_period = 0;
    longint exp_high = 0;
    int wp [4];
    int wh [4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) valid_cnt++;
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
            to_busy = busy;
        end
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected result of a measurement over the first NPER generated periods
    task automatic model_result(output longint p, output longint h);
        longint sp = 0;
        longint sh = 0;
        for (int i = 0; i < NPER; i++) begin
            sp += wp[i];
            sh += wh[i];
        end
        p = sp / NPER;
        h = sh / NPER;
    endtask

    task automatic run_meas(input string tag, input int start_step);
        int v0, t0, step;
        longint ep, eh;
        v0 = valid_cnt;
        t0 = to_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        step = 0;
        for (int i = 0; i < NPER; i++) begin
            for (int j = 0; j < wp[i]; j++) begin
                sig_in = (j < wh[i]);
                start  = (step == start_step);
                step++;
                @(negedge clk);
            end
        end
        sig_in = 1'b1;
        start  = 1'b0;
        @(negedge clk);
        sig_in = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (valid_cnt != v0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        model_result(ep, eh);
        exp_period = ep;
        exp_high   = eh;
        check({tag, "_valid_pulses"}, valid_cnt - v0, 1);
        check({tag, "_timeouts"}, to_cnt - t0, 0);
        check({tag, "_period"}, period_out, exp_period);
        check({tag, "_high"}, high_out, exp_high);
    endtask

    task automatic run_timeout(input string tag);
        int t0, v0, b0, sc;
        t0 = to_cnt;
        v0 = valid_cnt;
        @(negedge clk);
        b0 = busy_cnt;
        start = 1'b1;
        sc = cyc;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < TOUT + 50; k++) begin
            if (to_cnt != t0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check({tag, "_timeouts"}, to_cnt - t0, 1);
        check({tag, "_latency"}, to_cyc - sc, TOUT + 1);
        check({tag, "_busy_cycles"}, busy_cnt - b0, TOUT);
        check({tag, "_busy_at_to"}, to_busy, 0);
        check({tag, "_no_valid"}, valid_cnt - v0, 0);
        check({tag, "_period_kept"}, period_out, exp_period);
        check({tag, "_high_kept"}, high_out, exp_high);
    endtask

    task automatic fill(input int p, input int h);
        for (int i = 0; i < 4; i++) begin
            wp[i] = p;
            wh[i] = h;
        end
    endtask

    initial begin
        int v0;
        repeat (4) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_period", period_out, 0);
        check("rst_high", high_out, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        fill(10, 5);
        run_meas("div10", -1);
        fill(2, 1);
        run_meas("div2", -1);
        fill(10, 5);
        run_meas("div10b", -1);

        run_timeout("stuck_low");
        sig_in = 1'b1;
        repeat (5) @(negedge clk);
        run_timeout("stuck_high");
        sig_in = 1'b0;
        repeat (5) @(negedge clk);

        fill(20, 10);
        run_meas("restart_ignored", 10);

        // Reset in the middle of a measurement
        v0 = valid_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 12; j++) begin
            sig_in = (j < 10);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_period", period_out, 0);
        check("midrst_high", high_out, 0);
        rst = 1'b0;
        sig_in = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_no_valid", valid_cnt - v0, 0);
        exp_period = 0;
        exp_high = 0;
        fill(10, 5);
        run_meas("after_rst", -1);

`ifdef FREQ_METER_AVG4_EN
        wp[0] = 10; wh[0] = 5;
        wp[1] = 10; wh[1] = 5;
        wp[2] = 12; wh[2] = 6;
        wp[3] = 12; wh[3] = 6;
        run_meas("avg4", -1);
`endif

        for (int r = 0; r < 14; r++) begin
            for (int i = 0; i < 4; i++) begin
                wp[i] = $urandom_range(40, 2);
                wh[i] = $urandom_range(wp[i] - 1, 1);
            end
            run_meas($sformatf("rand%0d", r), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
